// File: rtl/i2c_regfile_if.sv
// Register bus between i2c_slave (master side) and i2c_regfile (slave side).
// reg_rdata is a zero-latency combinational return path.
interface i2c_regfile_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_wr, reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wr, reg_rd,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_regfile.sv
// Byte-wide register file behind i2c_slave: ID/version, control, scratch, synced status,
// W1C event flags with masked irq, access counters and a snapshot-able timestamp.
module i2c_regfile #(
  parameter logic [7:0]  DEV_ID  = 8'hA5,
  parameter logic [7:0]  VERSION = 8'h01,
  parameter int unsigned TS_DIV  = 100
) (
  input  logic           clk,
  input  logic           rst,
  i2c_regfile_if.slave   bus,
  input  logic [7:0]     status_i,
  input  logic [7:0]     evt_i,
  output logic [7:0]     ctrl_o,
  output logic           irq_o
);

  localparam int unsigned     PS_W   = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TS_DIV - 1);

  logic [7:0]      ctrl;
  logic [7:0]      scratch [4];
  logic [7:0]      evt_flags;
  logic [7:0]      evt_mask;
  logic [7:0]      wr_cnt;
  logic [7:0]      rd_cnt;
  logic [7:0]      status_s1;
  logic [7:0]      status_s2;
  logic [7:0]      evt_s1;
  logic [7:0]      evt_s2;
  logic [7:0]      evt_d;
  logic [1:0]      warm;
  logic [PS_W-1:0] presc;
  logic [31:0]     ts_cnt;
  logic [31:0]     ts_shadow;
  logic            irq_q;

  logic            wr_ctrl;
  logic            wr_scr;
  logic            wr_flags;
  logic            wr_mask;
  logic            wr_snap;
  logic            wr_accept;
  logic            armed;
  logic            ts_tick;
  logic [7:0]      evt_rise;
  logic [7:0]      flags_next;
  logic [7:0]      mask_next;

  always_comb begin
    wr_ctrl   = bus.reg_wr && (bus.reg_addr == 8'h02);
    wr_scr    = bus.reg_wr && (bus.reg_addr[7:2] == 6'b000001);
    wr_flags  = bus.reg_wr && (bus.reg_addr == 8'h08);
    wr_mask   = bus.reg_wr && (bus.reg_addr == 8'h09);
    wr_snap   = bus.reg_wr && (bus.reg_addr == 8'h0C);
    wr_accept = wr_ctrl | wr_scr | wr_flags | wr_mask | wr_snap;
  end

  // Sync pipeline is refilled from zero after reset; suppress the fake edge
  // that a level held high through reset would otherwise produce.
  assign armed      = (warm == 2'd3);
  assign evt_rise   = armed ? (evt_s2 & ~evt_d) : 8'h00;
  assign flags_next = (evt_flags & ~(wr_flags ? bus.reg_wdata : 8'h00)) | evt_rise;
  assign mask_next  = wr_mask ? bus.reg_wdata : evt_mask;
  assign ts_tick    = (presc == PS_MAX);

  always_comb begin
    bus.reg_rdata = 8'h00;
    case (bus.reg_addr)
      8'h00:                      bus.reg_rdata = DEV_ID;
      8'h01:                      bus.reg_rdata = VERSION;
      8'h02:                      bus.reg_rdata = ctrl;
      8'h03:                      bus.reg_rdata = status_s2;
      8'h04, 8'h05, 8'h06, 8'h07: bus.reg_rdata = scratch[bus.reg_addr[1:0]];
      8'h08:                      bus.reg_rdata = evt_flags;
      8'h09:                      bus.reg_rdata = evt_mask;
      8'h0A:                      bus.reg_rdata = wr_cnt;
      8'h0B:                      bus.reg_rdata = rd_cnt;
      8'h0D:                      bus.reg_rdata = ts_shadow[7:0];
      8'h0E:                      bus.reg_rdata = ts_shadow[15:8];
      8'h0F:                      bus.reg_rdata = ts_shadow[23:16];
      8'h10:                      bus.reg_rdata = ts_shadow[31:24];
      default:                    bus.reg_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= 8'h00;
      for (int i = 0; i < 4; i++) scratch[i] <= 8'h00;
      evt_flags <= 8'h00;
      evt_mask  <= 8'h00;
      wr_cnt    <= 8'h00;
      rd_cnt    <= 8'h00;
      status_s1 <= 8'h00;
      status_s2 <= 8'h00;
      evt_s1    <= 8'h00;
      evt_s2    <= 8'h00;
      evt_d     <= 8'h00;
      warm      <= 2'd0;
      presc     <= '0;
      ts_cnt    <= 32'h0;
      ts_shadow <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      status_s1 <= status_i;
      status_s2 <= status_s1;
      evt_s1    <= evt_i;
      evt_s2    <= evt_s1;
      evt_d     <= evt_s2;
      if (!armed) warm <= warm + 2'd1;

      if (wr_ctrl) ctrl <= bus.reg_wdata;
      if (wr_scr)  scratch[bus.reg_addr[1:0]] <= bus.reg_wdata;
      evt_flags <= flags_next;
      evt_mask  <= mask_next;
      irq_q     <= |(flags_next & mask_next);

      if (wr_accept)  wr_cnt <= wr_cnt + 8'd1;
      if (bus.reg_rd) rd_cnt <= rd_cnt + 8'd1;

      presc  <= ts_tick ? '0 : presc + PS_W'(1);
      ts_cnt <= ts_cnt + (ts_tick ? 32'd1 : 32'd0);
      // Shadow takes the pre-increment count so a burst read of 0D-10 is coherent.
      if (wr_snap) ts_shadow <= ts_cnt;
    end
  end

  assign ctrl_o = ctrl;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_i2c_regfile.sv
// Bench for i2c_regfile: directed register scenarios followed by random bus/event traffic,
// all checked against a transaction-level model of the register map.
module tb_i2c_regfile;
  localparam int unsigned TS_DIV = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] status_i;
  logic [7:0] evt_i;
  logic [7:0] ctrl_o;
  logic       irq_o;

  i2c_regfile_if bus ();

  i2c_regfile #(.DEV_ID(8'hA5), .VERSION(8'h01), .TS_DIV(TS_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .status_i (status_i),
    .evt_i    (evt_i),
    .ctrl_o   (ctrl_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0]  m_ctrl, m_flags, m_mask, m_wr, m_rd, m_status, st_prev;
  logic [7:0]  m_scr [4];
  logic [7:0]  ev_hist [4];
  logic [31:0] m_shadow;
  logic        m_irq;
  int unsigned n_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return 8'hA5;
      8'h01: return 8'h01;
      8'h02: return m_ctrl;
      8'h03: return m_status;
      8'h04, 8'h05, 8'h06, 8'h07: return m_scr[a - 8'h04];
      8'h08: return m_flags;
      8'h09: return m_mask;
      8'h0A: return m_wr;
      8'h0B: return m_rd;
      8'h0D: return m_shadow[7:0];
      8'h0E: return m_shadow[15:8];
      8'h0F: return m_shadow[23:16];
      8'h10: return m_shadow[31:24];
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge: inputs are already set up; update the model from what the edge saw.
  task automatic tick();
    logic [7:0] clr, rise;
    @(posedge clk);
    if (rst) begin
      m_ctrl = 0; m_flags = 0; m_mask = 0; m_wr = 0; m_rd = 0; m_status = 0; st_prev = 0;
      for (int i = 0; i < 4; i++) begin m_scr[i] = 0; ev_hist[i] = 0; end
      m_shadow = 0; m_irq = 0; n_edges = 0;
    end else begin
      n_edges++;
      for (int i = 3; i > 0; i--) ev_hist[i] = ev_hist[i-1];
      ev_hist[0] = evt_i;
      // an edge between samples taken 3 and 2 edges ago lands now, once the sync path has refilled
      rise = (n_edges >= 4) ? (ev_hist[2] & ~ev_hist[3]) : 8'h00;
      m_status = st_prev;
      st_prev  = status_i;
      clr = 8'h00;
      if (bus.reg_wr) begin
        case (bus.reg_addr)
          8'h02: begin m_ctrl = bus.reg_wdata; m_wr++; end
          8'h04, 8'h05, 8'h06, 8'h07: begin m_scr[bus.reg_addr - 8'h04] = bus.reg_wdata; m_wr++; end
          8'h08: begin clr = bus.reg_wdata; m_wr++; end
          8'h09: begin m_mask = bus.reg_wdata; m_wr++; end
          8'h0C: begin m_shadow = (n_edges - 1) / TS_DIV; m_wr++; end
          default: ;
        endcase
      end
      if (bus.reg_rd) m_rd++;
      m_flags = (m_flags & ~clr) | rise;
      m_irq   = |(m_flags & m_mask);
    end
    #1;
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wr = 1'b1;
    tick();
    bus.reg_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.reg_addr = a;
    #1;
    chk(tag, bus.reg_rdata, exp);
  endtask

  initial begin
    logic [7:0] w0, r;
    rst = 1'b1; status_i = 8'h00; evt_i = 8'h00;
    bus.reg_addr = 8'h00; bus.reg_wdata = 8'h00; bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
    #2;
    // reset
    tick(); tick();
    rst = 1'b0;
    rd_chk("rst_id", 8'h00, 8'hA5);
    rd_chk("rst_ver", 8'h01, 8'h01);
    rd_chk("rst_ctrl", 8'h02, 8'h00);
    rd_chk("rst_flags", 8'h08, 8'h00);
    rd_chk("rst_wrcnt", 8'h0A, 8'h00);
    chk("rst_ctrl_o", ctrl_o, 8'h00);
    chk("rst_irq", irq_o, 1'b0);

    // CTRL write and RO write
    do_wr(8'h02, 8'h3C);
    chk("ctrl_o", ctrl_o, 8'h3C);
    rd_chk("ctrl_rd", 8'h02, 8'h3C);
    rd_chk("wrcnt1", 8'h0A, 8'h01);
    do_wr(8'h00, 8'hFF);
    rd_chk("id_ro", 8'h00, 8'hA5);
    rd_chk("wrcnt_ro", 8'h0A, 8'h01);

    // events, mask, W1C, set-wins
    evt_i = 8'h04;
    tick(); tick(); tick();
    evt_i = 8'h00;
    tick();
    rd_chk("evt_flag", 8'h08, 8'h04);
    chk("irq_masked", irq_o, 1'b0);
    do_wr(8'h09, 8'h04);
    chk("irq_set", irq_o, 1'b1);
    do_wr(8'h08, 8'h04);
    rd_chk("w1c", 8'h08, 8'h00);
    chk("irq_clr", irq_o, 1'b0);
    tick(); tick(); tick();
    evt_i = 8'h04;
    tick(); tick();
    do_wr(8'h08, 8'h04);
    rd_chk("set_wins", 8'h08, 8'h04);
    chk("set_wins_irq", irq_o, 1'b1);
    evt_i = 8'h00;

    // status sync
    status_i = 8'h5A;
    tick(); tick();
    rd_chk("status", 8'h03, 8'h5A);

    // snapshot coherence
    do_wr(8'h0C, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick(); tick(); tick(); tick(); tick();
      r = 8'h0D + 8'(i);
      rd_chk("snap_byte", r, model_read(r));
    end
    chk("snap_val", m_shadow, (n_edges - 21) / TS_DIV);
    rd_chk("snap_reads0", 8'h0C, 8'h00);

    // mid-op reset with events high
    evt_i = 8'hFF;
    bus.reg_addr = 8'h02; bus.reg_wdata = 8'hAA; bus.reg_wr = 1'b1; rst = 1'b1;
    tick();
    bus.reg_wr = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("midrst_ctrl", ctrl_o, 8'h00);
    rd_chk("midrst_flags", 8'h08, 8'h00);
    chk("midrst_irq", irq_o, 1'b0);
    evt_i = 8'h00;

    // counter wrap
    w0 = m_wr;
    for (int i = 0; i < 256; i++) do_wr(8'h04, 8'(i));
    rd_chk("wrcnt_wrap", 8'h0A, w0);
    rd_chk("scratch0", 8'h04, 8'hFF);
    for (int i = 0; i < 3; i++) begin bus.reg_rd = 1'b1; tick(); bus.reg_rd = 1'b0; tick(); end
    rd_chk("rdcnt", 8'h0B, 8'h03);

    // random traffic against the model
    for (int it = 0; it < 3000; it++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.reg_wr = ($urandom_range(0, 9) < 4);
      bus.reg_rd = ($urandom_range(0, 9) < 3);
      bus.reg_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
      bus.reg_wdata = 8'($urandom);
      if ($urandom_range(0, 2) == 0) evt_i = evt_i ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) status_i = 8'($urandom);
      tick();
      bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; rst = 1'b0;
      chk("rnd_ctrl_o", ctrl_o, m_ctrl);
      chk("rnd_irq", irq_o, m_irq);
      r = 8'($urandom_range(0, 18));
      rd_chk("rnd_rdata", r, model_read(r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
